// File: rtl/led_pattern_decoder.sv
// led_pattern_decoder: passive monitor that recovers which LED pattern family
//   (rotate left/right, invert, increment, decrement) drives an 8-bit LED bus.
// Latency: led_in sampled at edge N -> step/class/lock/period update at edge N+2.
// Backpressure: none; a new LED value may be observed on every clock.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   led_in[7:0] observed LED bus, synchronous to clk
//   step        one-cycle pulse per detected LED change
//   step_class  lowest class id matched by the latest step, 7 = none
//   locked      some class has LOCK_COUNT consecutive matching steps
//   pat_id      lowest locked class id, 7 when not locked
//   period      clocks between the last two steps, saturating
//   paused      no step seen for TIMEOUT clocks
//
// Build option: define LED_PATTERN_DECODER_PERIOD_EN to build the interval
//   counter, period and paused outputs; otherwise period and paused read 0.
//
// Class ids: 0 rotl, 1 rotr, 2 inv, 3 inc, 4 dec (all mod 256).

module led_pattern_decoder #(
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 24,
  parameter int TIMEOUT    = 12_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       led_in,
  output logic             step,
  output logic [2:0]       step_class,
  output logic             locked,
  output logic [2:0]       pat_id,
  output logic [CNT_W-1:0] period,
  output logic             paused
);

  localparam int         NCLS     = 5;
  localparam logic [3:0] RUN_MAX  = 4'(LOCK_COUNT);
  localparam logic [2:0] NO_CLASS = 3'd7;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the bus and compare against the previous sample.
  // ---------------------------------------------------------------------------
  logic [7:0]      cur_q;
  logic [7:0]      prev_q;
  logic            det_step;
  logic [NCLS-1:0] det_match;

  always_comb begin
    det_step     = (cur_q != prev_q);
    det_match[0] = (cur_q == {prev_q[6:0], prev_q[7]});
    det_match[1] = (cur_q == {prev_q[0], prev_q[7:1]});
    det_match[2] = (cur_q == ~prev_q);
    det_match[3] = (cur_q == prev_q + 8'd1);
    det_match[4] = (cur_q == prev_q - 8'd1);
  end

  // ---------------------------------------------------------------------------
  // Stage 2: register the step decision and its class flags.  Flags are
  // masked with the step so a constant bus (e.g. 0x00 or 0xFF, which equals
  // its own rotation) never looks like a matching step.
  // ---------------------------------------------------------------------------
  logic            step_d;
  logic [NCLS-1:0] match_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= 8'h00;
      prev_q  <= 8'h00;
      step_d  <= 1'b0;
      match_d <= '0;
    end else begin
      cur_q   <= led_in;
      prev_q  <= cur_q;
      step_d  <= det_step;
      match_d <= det_match & {NCLS{det_step}};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: per-class run counters and the lock decision.
  // ---------------------------------------------------------------------------
  logic [NCLS-1:0][3:0] cnt_q;
  logic [NCLS-1:0][3:0] cnt_n;
  logic [2:0]           cls_n;
  logic                 lock_n;
  logic [2:0]           pat_n;

  always_comb begin
    cnt_n = cnt_q;
    if (step_d) begin
      for (int i = 0; i < NCLS; i++) begin
        if (!match_d[i]) begin
          cnt_n[i] = 4'd0;
        end else if (cnt_q[i] != RUN_MAX) begin
          cnt_n[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Lowest id wins in both searches, so scan from the top down and let the
  // last hit overwrite.
  always_comb begin
    cls_n = step_class;
    if (step_d) begin
      cls_n = NO_CLASS;
      for (int i = NCLS - 1; i >= 0; i--) begin
        if (match_d[i]) begin
          cls_n = 3'(i);
        end
      end
    end
  end

  // Lock is taken from the next-state counters so it moves on the same edge
  // as the counters; a step that breaks every saturated run unlocks at once.
  always_comb begin
    lock_n = 1'b0;
    pat_n  = NO_CLASS;
    for (int i = NCLS - 1; i >= 0; i--) begin
      if (cnt_n[i] == RUN_MAX) begin
        lock_n = 1'b1;
        pat_n  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      step       <= 1'b0;
      step_class <= NO_CLASS;
      locked     <= 1'b0;
      pat_id     <= NO_CLASS;
    end else begin
      cnt_q      <= cnt_n;
      step       <= step_d;
      step_class <= cls_n;
      locked     <= lock_n;
      pat_id     <= pat_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Step interval measurement and stall detection.
  // ---------------------------------------------------------------------------
`ifdef LED_PATTERN_DECODER_PERIOD_EN

  localparam logic [CNT_W-1:0] IVL_MAX = '1;
  localparam logic [CNT_W-1:0] IVL_TMO = CNT_W'(TIMEOUT);

  // ivl counts clocks since the last step edge; it reads 1 on the clock after
  // a step, so at the next step it equals the step-to-step distance.
  logic [CNT_W-1:0] ivl_q;
  logic [CNT_W-1:0] ivl_n;
  logic             seen_q;

  always_comb begin
    ivl_n = ivl_q;
    if (step_d) begin
      ivl_n = CNT_W'(1);
    end else if (ivl_q != IVL_MAX) begin
      ivl_n = ivl_q + CNT_W'(1);
    end
  end

  // The first step after reset has no predecessor to measure against, so it
  // only arms seen_q; period and the stall timer start from the second.
  always_ff @(posedge clk) begin
    if (rst) begin
      ivl_q  <= '0;
      seen_q <= 1'b0;
      period <= '0;
      paused <= 1'b0;
    end else begin
      ivl_q <= ivl_n;
      if (step_d) begin
        seen_q <= 1'b1;
        paused <= 1'b0;
        if (seen_q) begin
          period <= ivl_q;
        end
      end else if (seen_q && (ivl_n >= IVL_TMO)) begin
        paused <= 1'b1;
      end
    end
  end

`else

  // Measurement not built: outputs are constant and the timing parameters
  // have no function.
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT;
  assign period     = '0;
  assign paused     = 1'b0;

`endif

endmodule

// File: tb/tb_led_pattern_decoder.sv
// tb_led_pattern_decoder: table-driven stimulus with a scoreboard queue.
// Each applied LED value pushes the outputs expected at its step pulse; a
// negedge monitor pops and compares whenever the DUT pulses step.

module tb_led_pattern_decoder;

  localparam int LOCK_COUNT = 4;
  localparam int CNT_W      = 5;
  localparam int TIMEOUT    = 20;
  localparam int NVEC       = 37;

`ifdef LED_PATTERN_DECODER_PERIOD_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic [7:0]       led_in = 8'h00;
  logic             step;
  logic [2:0]       step_class;
  logic             locked;
  logic [2:0]       pat_id;
  logic [CNT_W-1:0] period;
  logic             paused;

  led_pattern_decoder #(
    .LOCK_COUNT (LOCK_COUNT),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .step       (step),
    .step_class (step_class),
    .locked     (locked),
    .pat_id     (pat_id),
    .period     (period),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] cls;
    logic       lk;
    logic [2:0] pid;
    logic [7:0] per;
  } exp_t;

  typedef struct {
    logic [7:0] v;
    int         hold;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   step_idx = 0;
  exp_t got_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] v, input int hold, input int cls,
                              input int lk, input int pid, input int per);
    vec_t r;
    r.v     = v;
    r.hold  = hold;
    r.e.cls = 3'(cls);
    r.e.lk  = 1'(lk);
    r.e.pid = 3'(pid);
    r.e.per = 8'(per);
    return r;
  endfunction

  // Put a value on the bus (one clock after a posedge), queue what its step
  // must report, and keep it for 'hold' sampling edges.
  task automatic drive(input vec_t r);
    exp_t x;
    x = r.e;
    if (!PER_EN) x.per = 8'd0;
    led_in = r.v;
    exp_q.push_back(x);
    repeat (r.hold) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_step"},       32'(step),       32'd0);
    chk({tag, "_step_class"}, 32'(step_class), 32'd7);
    chk({tag, "_locked"},     32'(locked),     32'd0);
    chk({tag, "_pat_id"},     32'(pat_id),     32'd7);
    chk({tag, "_period"},     32'(period),     32'd0);
    chk({tag, "_paused"},     32'(paused),     32'd0);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_pending_steps"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL step%0d_unexpected: actual step=1 required no step pending", step_idx);
      end else begin
        got_e = exp_q.pop_front();
        chk($sformatf("step%0d_class", step_idx),  32'(step_class), 32'(got_e.cls));
        chk($sformatf("step%0d_locked", step_idx), 32'(locked),     32'(got_e.lk));
        chk($sformatf("step%0d_pat_id", step_idx), 32'(pat_id),     32'(got_e.pid));
        chk($sformatf("step%0d_period", step_idx), 32'(period),     32'(got_e.per));
        chk($sformatf("step%0d_paused", step_idx), 32'(paused),     32'd0);
      end
      step_idx++;
    end
  end

  initial begin
    vec_t tbl[NVEC];
    int   k;

    //            value  hold cls lk pid per
    // rotate left 0x01..0x10 every 10 clocks (0x00->0x01 is an inc step)
    tbl[0]  = mk(8'h01, 10, 3, 0, 7, 0);
    tbl[1]  = mk(8'h02, 10, 0, 0, 7, 10);
    tbl[2]  = mk(8'h04, 10, 0, 0, 7, 10);
    tbl[3]  = mk(8'h08, 10, 0, 0, 7, 10);
    tbl[4]  = mk(8'h10, 10, 0, 1, 0, 10);
    // counter every 3 clocks; rotl breaks at 0x02->0x03
    tbl[5]  = mk(8'h00, 3, 7, 0, 7, 10);
    tbl[6]  = mk(8'h01, 3, 3, 0, 7, 3);
    tbl[7]  = mk(8'h02, 3, 0, 0, 7, 3);
    tbl[8]  = mk(8'h03, 3, 3, 0, 7, 3);
    tbl[9]  = mk(8'h04, 3, 3, 1, 3, 3);
    tbl[10] = mk(8'h05, 3, 3, 1, 3, 3);
    // inversion 0x0F/0xF0 every 5 clocks
    tbl[11] = mk(8'h0F, 5, 7, 0, 7, 3);
    tbl[12] = mk(8'hF0, 5, 2, 0, 7, 5);
    tbl[13] = mk(8'h0F, 5, 2, 0, 7, 5);
    tbl[14] = mk(8'hF0, 5, 2, 0, 7, 5);
    tbl[15] = mk(8'h0F, 5, 2, 1, 2, 5);
    tbl[16] = mk(8'hF0, 5, 2, 1, 2, 5);
    // 0x55/0xAA matches rotl, rotr and inv -> decodes as 0
    tbl[17] = mk(8'h55, 4, 7, 0, 7, 5);
    tbl[18] = mk(8'hAA, 4, 0, 0, 7, 4);
    tbl[19] = mk(8'h55, 4, 0, 0, 7, 4);
    tbl[20] = mk(8'hAA, 4, 0, 0, 7, 4);
    tbl[21] = mk(8'h55, 4, 0, 1, 0, 4);
    // inc lock through the 0xFF->0x00 wrap, then break on 0x37
    tbl[22] = mk(8'hFB, 2, 7, 0, 7, 4);
    tbl[23] = mk(8'hFC, 2, 3, 0, 7, 2);
    tbl[24] = mk(8'hFD, 2, 3, 0, 7, 2);
    tbl[25] = mk(8'hFE, 2, 1, 0, 7, 2);
    tbl[26] = mk(8'hFF, 2, 3, 1, 3, 2);
    tbl[27] = mk(8'h00, 1, 2, 1, 3, 2);
    tbl[28] = mk(8'h37, 1, 7, 0, 7, 1);
    // a step on every clock, relock on inc from zeroed counters
    tbl[29] = mk(8'h38, 1, 3, 0, 7, 1);
    tbl[30] = mk(8'h39, 1, 3, 0, 7, 1);
    tbl[31] = mk(8'h3A, 1, 3, 0, 7, 1);
    tbl[32] = mk(8'h3B, 1, 3, 1, 3, 1);
    // decrement lock
    tbl[33] = mk(8'h3A, 3, 4, 0, 7, 1);
    tbl[34] = mk(8'h39, 3, 4, 0, 7, 3);
    tbl[35] = mk(8'h38, 3, 4, 0, 7, 3);
    tbl[36] = mk(8'h37, 3, 4, 1, 4, 3);

    rst    = 1'b1;
    led_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i]);
    end

    // Pause: one more dec step, then hold the bus still.
    drive(mk(8'h36, 1, 4, 1, 4, 3));
    k = 0;
    while (step !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("pause_step_seen", 32'(step), 32'd1);
    k = 0;
    while (paused !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("pause_latency", 32'(k), PER_EN ? 32'd19 : 32'd40);
    chk("pause_level",   32'(paused), 32'(PER_EN));
    chk("pause_locked",  32'(locked), 32'd1);
    chk("pause_pat_id",  32'(pat_id), 32'd4);
    chk("pause_period",  32'(period), PER_EN ? 32'd3 : 32'd0);
    repeat (21) @(posedge clk);
    #1;
    // Interval well beyond 2^CNT_W-1: period saturates, paused clears.
    drive(mk(8'h35, 5, 4, 1, 4, 31));
    drain("drain_pause");

    // Reset mid-stream while locked.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("midreset");
    // 0x35 still on the bus: one step against 0x00, no period update.
    drive(mk(8'h35, 5, 7, 0, 7, 0));
    drive(mk(8'h34, 4, 4, 0, 7, 5));
    drive(mk(8'h33, 4, 4, 0, 7, 4));
    drive(mk(8'h32, 4, 4, 0, 7, 4));
    drive(mk(8'h31, 4, 4, 1, 4, 4));
    drain("drain_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL watchdog: actual test still running required completion within 5000 clocks");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
